kmeans_centroid_update: RTL

- Downstream stage of kmeans_cluster. Consumes each classified sample (data vector plus assigned cluster index) and accumulates a per-cluster, per-parameter sum and a per-cluster count.
- On an epoch-end request, divides each sum by its count, one element at a time, using an iterative divider.
- Publishes the new centroid vector in exactly the packed format and with the valid strobe that kmeans_cluster takes on centroid_i / centroid_valid_i, which closes the k-means iteration loop in hardware.

---
 rtl/kmeans_pkg.sv | 26 ++
 rtl/kmeans_seq_divider.sv | 58 +++++
 rtl/kmeans_centroid_update.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means centroid update slice.
//   upd_state_e     : update FSM states
//   STAT_*          : bit positions inside status_o
//   sum_width()     : accumulator width derived from feature and counter widths
package kmeans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    STORE,
    DONE
  } upd_state_e;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_SAT       = 1;
  localparam int unsigned STAT_DROP      = 2;
  localparam int unsigned STAT_EMPTY_LSB = 8;
  localparam int unsigned STAT_EMPTY_W   = 8;

  // A count below 2^cnt_w samples of dw-bit values never overflows dw+cnt_w bits.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned cnt_w);
    return dw + cnt_w;
  endfunction

endpackage

// File: rtl/kmeans_seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, reset : clock, synchronous active-high reset
//   start      : latch dividend/divisor and begin (ignored values while busy are overwritten)
//   dividend   : SUM_W-bit numerator
//   divisor    : CNT_W-bit denominator (caller guarantees non-zero)
//   done       : high during the final iteration cycle; quotient is valid from the next cycle
//   quotient   : SUM_W-bit result
module kmeans_seq_divider #(
  parameter int unsigned SUM_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             done,
  output logic [SUM_W-1:0] quotient
);

  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  // Remainder is always below the divisor, so CNT_W bits hold it.
  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  dsr;
  logic [STEP_W-1:0] steps;
  logic [CNT_W:0]    trial;

  // quotient doubles as the dividend shift register: its MSB feeds the remainder.
  always_comb begin
    trial = {rem, quotient[SUM_W-1]};
    done  = (steps == STEP_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      steps    <= '0;
    end else if (start) begin
      rem      <= '0;
      dsr      <= divisor;
      quotient <= dividend;
      steps    <= STEP_W'(SUM_W);
    end else if (steps != '0) begin
      if (trial >= {1'b0, dsr}) begin
        rem      <= CNT_W'(trial - {1'b0, dsr});
        quotient <= {quotient[SUM_W-2:0], 1'b1};
      end else begin
        rem      <= trial[CNT_W-1:0];
        quotient <= {quotient[SUM_W-2:0], 1'b0};
      end
      steps <= steps - STEP_W'(1);
    end
  end

endmodule

// File: rtl/kmeans_centroid_update.sv
// Accumulates classified samples per cluster and, on update_i, recomputes each
// centroid element as sum/count with a shared sequential divider, then pulses
// centroid_valid_o so kmeans_cluster can take the new centroids.
//   init_centroid_i/init_valid_i : seed centroid load (IDLE only)
//   data_i/cluster_i/valid_i     : classified sample input; ready_o high in IDLE
//   clear_i                      : zero accumulators, counts and sticky bits
//   update_i                     : start recomputation
//   centroid_o/centroid_valid_o  : centroids ([c][p] at (c*PARAMS+p)*DW) and refresh pulse
//   busy_o                       : FSM not in IDLE
//   status_o                     : [0] busy, [1] count saturated, [2] sample dropped,
//                                  [15:8] empty-cluster mask of the last update
// Optional build macro KMEANS_UPD_ROUND_EN: round-half-up instead of floor division.
module kmeans_centroid_update
  import kmeans_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned CLUSTERS = 2,
  parameter int unsigned PARAMS   = 13,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [CLUSTERS*PARAMS*DW-1:0]   init_centroid_i,
  input  logic                            init_valid_i,
  input  logic [PARAMS*DW-1:0]            data_i,
  input  logic [$clog2(CLUSTERS)-1:0]     cluster_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  input  logic                            clear_i,
  input  logic                            update_i,
  output logic [CLUSTERS*PARAMS*DW-1:0]   centroid_o,
  output logic                            centroid_valid_o,
  output logic                            busy_o,
  output logic [31:0]                     status_o
);

  localparam int unsigned SUM_W = sum_width(DW, CNT_W);
  localparam int unsigned CI_W  = $clog2(CLUSTERS);
  localparam int unsigned PI_W  = (PARAMS > 1) ? $clog2(PARAMS) : 1;

  upd_state_e          state;
  logic [CI_W-1:0]     c_idx;
  logic [PI_W-1:0]     p_idx;
  logic                skip;
  logic [SUM_W-1:0]    sum_acc [CLUSTERS][PARAMS];
  logic [CNT_W-1:0]    cnt_acc [CLUSTERS];
  logic                sat_flag;
  logic                drop_flag;
  logic [CLUSTERS-1:0] empty_acc;
  logic [CLUSTERS-1:0] empty_mask;

  logic [SUM_W-1:0] cur_sum;
  logic [CNT_W-1:0] cur_cnt;
  logic [SUM_W-1:0] dividend;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] quotient;
  logic [DW-1:0]    store_val;
  logic             sample_ok;

  always_comb begin
    cur_sum = sum_acc[c_idx][p_idx];
    cur_cnt = cnt_acc[c_idx];
`ifdef KMEANS_UPD_ROUND_EN
    dividend = cur_sum + SUM_W'(cur_cnt >> 1);
`else
    dividend = cur_sum;
`endif
    div_start = (state == LOAD) && (cur_cnt != '0);
    // The mean never exceeds a DW-bit value, so the clamp only bites on rounding overshoot.
    store_val = (|quotient[SUM_W-1:DW]) ? '1 : quotient[DW-1:0];
    sample_ok = 32'(cluster_i) < CLUSTERS;
  end

  kmeans_seq_divider #(
    .SUM_W(SUM_W),
    .CNT_W(CNT_W)
  ) u_div (
    .clk      (clk_i),
    .reset    (reset_i),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (cur_cnt),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= IDLE;
      c_idx            <= '0;
      p_idx            <= '0;
      skip             <= 1'b0;
      sat_flag         <= 1'b0;
      drop_flag        <= 1'b0;
      empty_acc        <= '0;
      empty_mask       <= '0;
      centroid_o       <= '0;
      centroid_valid_o <= 1'b0;
      busy_o           <= 1'b0;
      ready_o          <= 1'b1;
      for (int unsigned c = 0; c < CLUSTERS; c++) begin
        cnt_acc[c] <= '0;
        for (int unsigned p = 0; p < PARAMS; p++) sum_acc[c][p] <= '0;
      end
    end else begin
      centroid_valid_o <= 1'b0;
      if (state != IDLE && valid_i) drop_flag <= 1'b1;

      case (state)
        IDLE: begin
          if (clear_i) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
            for (int unsigned c = 0; c < CLUSTERS; c++) begin
              cnt_acc[c] <= '0;
              for (int unsigned p = 0; p < PARAMS; p++) sum_acc[c][p] <= '0;
            end
          end else begin
            // Sample is taken alongside init/update so an update includes it.
            if (valid_i) begin
              if (!sample_ok) begin
                drop_flag <= 1'b1;
              end else if (cnt_acc[cluster_i] == '1) begin
                sat_flag <= 1'b1;
              end else begin
                cnt_acc[cluster_i] <= cnt_acc[cluster_i] + CNT_W'(1);
                for (int unsigned p = 0; p < PARAMS; p++)
                  sum_acc[cluster_i][p] <= sum_acc[cluster_i][p] + SUM_W'(data_i[p*DW +: DW]);
              end
            end
            if (init_valid_i) begin
              centroid_o <= init_centroid_i;
            end else if (update_i) begin
              state     <= LOAD;
              c_idx     <= '0;
              p_idx     <= '0;
              empty_acc <= '0;
              busy_o    <= 1'b1;
              ready_o   <= 1'b0;
            end
          end
        end

        LOAD: begin
          skip <= (cur_cnt == '0);
          if (cur_cnt == '0) begin
            empty_acc[c_idx] <= 1'b1;
            state            <= STORE;
          end else begin
            state <= DIV;
          end
        end

        DIV: begin
          if (div_done) state <= STORE;
        end

        STORE: begin
          if (!skip) centroid_o[(32'(c_idx) * PARAMS + 32'(p_idx)) * DW +: DW] <= store_val;
          if (32'(p_idx) == PARAMS - 1) begin
            p_idx <= '0;
            if (32'(c_idx) == CLUSTERS - 1) begin
              state <= DONE;
            end else begin
              c_idx <= c_idx + CI_W'(1);
              state <= LOAD;
            end
          end else begin
            p_idx <= p_idx + PI_W'(1);
            state <= LOAD;
          end
        end

        DONE: begin
          centroid_valid_o <= 1'b1;
          empty_mask       <= empty_acc;
          state            <= IDLE;
          busy_o           <= 1'b0;
          ready_o          <= 1'b1;
          for (int unsigned c = 0; c < CLUSTERS; c++) begin
            cnt_acc[c] <= '0;
            for (int unsigned p = 0; p < PARAMS; p++) sum_acc[c][p] <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status_o            = '0;
    status_o[STAT_BUSY] = busy_o;
    status_o[STAT_SAT]  = sat_flag;
    status_o[STAT_DROP] = drop_flag;
    for (int unsigned c = 0; c < CLUSTERS; c++)
      if (c < STAT_EMPTY_W) status_o[STAT_EMPTY_LSB + c] = empty_mask[c];
  end

endmodule
